// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C responder: FSM states, R/W and ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic WRITE    = 1'b0;
  localparam logic READ     = 1'b1;
  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchronizers, optional glitch filter (I2C_SLV_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection from the current and previous conditioned samples.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : g_bad_param
    $error("i2c_line_cond: SYNC_STAGES must be 2..4 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [1:0] raw, filt, prev;   // bit 1 = SCL, bit 0 = SDA

  // Sync flops reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop sees pre-edge values.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign raw = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] cnt [2];

  // A line only changes after FILTER_LEN consecutive samples disagreeing with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 2'b11;
    else     prev <= filt;
  end

  assign sda_lvl   = filt[0];
  assign scl_rise  =  filt[1] & ~prev[1];
  assign scl_fall  = ~filt[1] &  prev[1];
  assign start_det =  filt[1] &  prev[1] &  prev[0] & ~filt[0];
  assign stop_det  =  filt[1] &  prev[1] & ~prev[0] &  filt[0];

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: decodes START/STOP, matches SLAVE_ADDR, receives write bytes and
// serializes host-supplied read bytes. Open-drain: only ever pulls SDA low.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h72,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       busy_o
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_line_cond (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_lvl  (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [6:0] tx_sh;      // remaining read bits; bit 7 goes out at load time
  logic       byte_done;  // 8th rising edge seen, act on the next falling edge
  logic       rw;
  logic       ack_bit;

  always_ff @(posedge clk) begin
    rx_valid_o <= 1'b0;
    tx_req_o   <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_sh     <= '0;
      byte_done <= 1'b0;
      rw        <= WRITE;
      ack_bit   <= NACK_LVL;
      sda_oe_o  <= 1'b0;
      rx_data_o <= '0;
      busy_o    <= 1'b0;
    end else if (stop_det) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      sda_oe_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else if (start_det) begin
      // busy_o is left alone on a repeated START until the next address result.
      state     <= ADDR;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      sda_oe_o  <= 1'b0;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_done <= 1'b1;
              if (state == WR_DATA) begin
                rx_data_o  <= {shreg[6:0], sda_lvl};
                rx_valid_o <= 1'b1;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            if (state == WR_DATA) begin
              sda_oe_o <= 1'b1;
              state    <= WR_ACK;
            end else if (shreg[7:1] == SLAVE_ADDR) begin
              sda_oe_o <= 1'b1;
              busy_o   <= 1'b1;
              rw       <= shreg[0];
              state    <= ADDR_ACK;
            end else begin
              busy_o <= 1'b0;
              state  <= IGNORE;
            end
          end
        end
        ADDR_ACK, RD_ACK: begin
          if (scl_rise) ack_bit <= sda_lvl;
          if (scl_fall) begin
            bit_cnt <= '0;
            if ((state == ADDR_ACK && rw == READ) || (state == RD_ACK && ack_bit == ACK_LVL)) begin
              tx_sh    <= tx_data_i[6:0];
              tx_req_o <= 1'b1;
              sda_oe_o <= ~tx_data_i[7];
              state    <= RD_DATA;
            end else begin
              sda_oe_o <= 1'b0;
              state    <= (state == ADDR_ACK) ? WR_DATA : IGNORE;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_o <= 1'b0;
            bit_cnt  <= '0;
            state    <= WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_o <= 1'b0;
              bit_cnt  <= '0;
              state    <= RD_ACK;
            end else begin
              sda_oe_o <= ~tx_sh[6];
              tx_sh    <= {tx_sh[5:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
        end
        default: ;  // IDLE and IGNORE only leave on START/STOP
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) that answers the I2C master core's transactions. Used on-board and in loopback benches so the master path can be exercised end to end without external silicon.
- Oversamples SCL/SDA on the system clock and decodes START, STOP and repeated-START conditions.
- Matches a 7-bit address, ACKs, and handles both directions:
  - Write transfers: delivers each received byte to a host port.
  - Read transfers: serializes bytes supplied by the host.
- Open-drain only: never drives SDA high, never drives SCL.

Parameters:
- SLAVE_ADDR, 7'h72: 7-bit address this responder ACKs.
- SYNC_STAGES, 2: synchronizer flops on SCL/SDA, legal range 2..4.
- FILTER_LEN, 4: stable-sample count, used only with the optional glitch filter.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. Synchronous, active-high.
- scl_i, input, 1: bus SCL level.
- sda_i, input, 1: bus SDA level.
- sda_oe_o, output, 1: 1 = pull SDA low, 0 = release.
- rx_data_o, output, 8: last byte written by the master.
- rx_valid_o, output, 1: one-clk pulse when rx_data_o updates.
- tx_data_i, input, 8: byte to return on a read. Sampled at load.
- tx_req_o, output, 1: one-clk pulse when tx_data_i is loaded.
- busy_o, output, 1: high from address match until STOP or abort.

Behaviour:
- Reset:
  - sda_oe_o=0, rx_data_o=8'h00, rx_valid_o=0, tx_req_o=0, busy_o=0.
  - FSM in IDLE; bit counter and shift registers cleared.
  - rst mid-transfer releases SDA on the next clk edge. The responder then stays IDLE until a fresh START.
- Input conditioning:
  - scl_i/sda_i pass through SYNC_STAGES flops.
  - Edge and condition detection compares the synchronized value with its previous sample.
  - Latency from pin to decision: SYNC_STAGES+1 clks.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Conditions are recognised in every state and take priority over data sampling in the same clk.
- Timing rules:
  - Data is sampled on SCL rising edge.
  - sda_oe_o changes only on SCL falling edge, or immediately on STOP/START/rst.
- FSM states:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits MSB first; bit 0 is R/W.
    - On the falling edge after bit 8, if addr==SLAVE_ADDR: assert sda_oe_o, set busy_o, go to ADDR_ACK.
    - Otherwise go to IGNORE, and sda_oe_o stays 0.
  - ADDR_ACK: on the next SCL falling edge, release the ACK.
    - Write: go to WR_DATA.
    - Read: load tx_data_i, pulse tx_req_o, drive bit 7 (sda_oe_o = ~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - At the 8th rising edge: update rx_data_o and pulse rx_valid_o.
    - At the following falling edge: assert ACK, go to WR_ACK.
  - WR_ACK: release on falling edge, go to WR_DATA. Bit counter resets to 0.
  - RD_DATA: on each falling edge drive the next bit. After bit 0's falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on rising edge.
    - ACK (0): at the falling edge load the next tx_data_i, pulse tx_req_o, go to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Exit and boundary conditions:
  - STOP in any state: go to IDLE, busy_o=0, sda_oe_o=0. A partial byte is discarded with no rx_valid_o.
  - Repeated START in any state: go to ADDR, bit counter=0, sda_oe_o=0; busy_o holds until the next address result.
  - Bytes per transaction are unbounded; the bit counter wraps 0..7 each byte.
  - rx_valid_o and tx_req_o never assert in the same clk.

Optional Feature:
- Macro: I2C_SLV_GLITCH_FILTER_EN.
- Defined: after synchronization, each of SCL and SDA passes through a filter.
  - The filtered value updates only after FILTER_LEN consecutive identical samples.
  - Pulses shorter than FILTER_LEN clks are ignored.
  - Adds FILTER_LEN clks of latency.
- Undefined: synchronized values are used directly, and FILTER_LEN is unused.

Decomposition:
- Shared package i2c_pkg holds:
  - the FSM state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - the R/W bit constants (WRITE=0, READ=1);
  - the ACK/NACK level constants.
- One sub-module, i2c_line_cond: sync, optional filter and edge/START/STOP detect. It is instantiated once for the SCL/SDA pair.

Test Plan:
- Write transaction: START, addr 0x72+W, byte 0x44, STOP.
  - sda_oe_o=1 during both ACK clocks.
  - rx_data_o=0x44 with one rx_valid_o pulse.
  - busy_o falls after STOP.
- Address mismatch: START, addr 0x33+W, byte 0x44.
  - sda_oe_o stays 0 throughout; no rx_valid_o; busy_o stays 0.
- Read transaction: START, 0x72+R, tx_data_i=0xAB, master NACK.
  - The SDA bit sequence seen by the master is 1,0,1,0,1,0,1,1.
  - Exactly one tx_req_o pulse; SDA released after the NACK.
- Repeated START: 0x72+W, 0x11, then Sr, 0x72+R, tx_data_i=0x5A, ACK then NACK.
  - rx_data_o=0x11.
  - Two tx_req_o pulses, and 0x5A is returned twice.
- STOP after 4 bits of a write byte.
  - FSM returns to IDLE; no rx_valid_o; rx_data_o is unchanged.
- rst asserted while driving the ACK.
  - sda_oe_o=0 one clk later; all outputs at reset values.
  - Data bytes before a new START are ignored.
